alu_issue: RTL and testbench

//  Issue-side counterpart of the ALU: accepts decoded RV32 instructions on a valid/ready

---
 rtl/alu_issue_pkg.sv | 76 +++++++
 rtl/alu_issue_decode.sv | 98 +++++++++
 rtl/alu_issue.sv | 166 ++++++++++++++++
 tb/tb_alu_issue.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue slice: aluop codes, RV32 opcodes, FSM states,
// operand selects and the writeback tag carried alongside the ALU pipeline.
package alu_issue_pkg;

   localparam logic [4:0] ALUOP_ADD    = 5'd0;
   localparam logic [4:0] ALUOP_SUB    = 5'd1;
   localparam logic [4:0] ALUOP_SLL    = 5'd2;
   localparam logic [4:0] ALUOP_XOR    = 5'd3;
   localparam logic [4:0] ALUOP_SRL    = 5'd4;
   localparam logic [4:0] ALUOP_SRA    = 5'd5;
   localparam logic [4:0] ALUOP_OR     = 5'd6;
   localparam logic [4:0] ALUOP_AND    = 5'd7;
   localparam logic [4:0] ALUOP_SLT    = 5'd8;
   localparam logic [4:0] ALUOP_SLTU   = 5'd9;
   localparam logic [4:0] ALUOP_MULH   = 5'd16;
   localparam logic [4:0] ALUOP_MULHSU = 5'd17;
   localparam logic [4:0] ALUOP_MULHU  = 5'd18;
   localparam logic [4:0] ALUOP_MUL    = 5'd22;
   localparam logic [4:0] ALUOP_DIV    = 5'd24;
   localparam logic [4:0] ALUOP_DIVU   = 5'd26;
   localparam logic [4:0] ALUOP_REM    = 5'd28;
   localparam logic [4:0] ALUOP_REMU   = 5'd30;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_DIV_HOLD = 1'b1} state_e;
   typedef enum logic [1:0] {OP1_RS1 = 2'd0, OP1_PC = 2'd1, OP1_ZERO = 2'd2} op1_sel_e;
   typedef enum logic [1:0] {OP2_RS2 = 2'd0, OP2_IMM = 2'd1, OP2_FOUR = 2'd2} op2_sel_e;

   typedef struct packed {
      logic       valid;
      logic       illegal;
      logic [4:0] rd;
   } wb_tag_t;

   // funct3 -> aluop for the shared OP / OP-IMM integer group
   function automatic logic [4:0] base_op(input logic [2:0] f3);
      case (f3)
         3'd0:    return ALUOP_ADD;
         3'd1:    return ALUOP_SLL;
         3'd2:    return ALUOP_SLT;
         3'd3:    return ALUOP_SLTU;
         3'd4:    return ALUOP_XOR;
         3'd5:    return ALUOP_SRL;
         3'd6:    return ALUOP_OR;
         default: return ALUOP_AND;
      endcase
   endfunction

   function automatic logic [4:0] muldiv_op(input logic [2:0] f3);
      case (f3)
         3'd0:    return ALUOP_MUL;
         3'd1:    return ALUOP_MULH;
         3'd2:    return ALUOP_MULHSU;
         3'd3:    return ALUOP_MULHU;
         3'd4:    return ALUOP_DIV;
         3'd5:    return ALUOP_DIVU;
         3'd6:    return ALUOP_REM;
         default: return ALUOP_REMU;
      endcase
   endfunction

   function automatic logic [31:0] shamt_zext(input logic [31:0] v);
      return {27'd0, v[4:0]};
   endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32 decode into aluop, operand selects, divide class and illegal flag.
// Optional macro RV32M_EN enables the M-extension (funct7=0000001) encodings.
module alu_issue_decode
   import alu_issue_pkg::*;
(
   input  logic [6:0] i_opcode,
   input  logic [2:0] i_funct3,
   input  logic [6:0] i_funct7,
   output logic [4:0] o_aluop,
   output op1_sel_e   o_op1_sel,
   output op2_sel_e   o_op2_sel,
   output logic       o_shift,
   output logic       o_is_div,
   output logic       o_illegal
);

   // opcode/funct field decode
   always_comb begin
      o_aluop   = ALUOP_ADD;
      o_op1_sel = OP1_RS1;
      o_op2_sel = OP2_RS2;
      o_shift   = 1'b0;
      o_is_div  = 1'b0;
      o_illegal = 1'b0;
      case (i_opcode)
         OPC_OP: begin
            if (i_funct7 == F7_BASE) begin
               o_aluop = base_op(i_funct3);
               o_shift = (i_funct3 == 3'd1) || (i_funct3 == 3'd5);
            end else if (i_funct7 == F7_ALT) begin
               if (i_funct3 == 3'd0) begin
                  o_aluop = ALUOP_SUB;
               end else if (i_funct3 == 3'd5) begin
                  o_aluop = ALUOP_SRA;
                  o_shift = 1'b1;
               end else begin
                  o_illegal = 1'b1;
               end
            end else if (i_funct7 == F7_MULDIV) begin
`ifdef RV32M_EN
               o_aluop  = muldiv_op(i_funct3);
               o_is_div = i_funct3[2];
`else
               o_illegal = 1'b1;
`endif
            end else begin
               o_illegal = 1'b1;
            end
         end
         OPC_OP_IMM: begin
            o_op2_sel = OP2_IMM;
            // funct7 here is imm[11:5]; it only qualifies the shift encodings
            if (i_funct3 == 3'd1) begin
               if (i_funct7 == F7_BASE) begin
                  o_aluop = ALUOP_SLL;
                  o_shift = 1'b1;
               end else begin
                  o_illegal = 1'b1;
               end
            end else if (i_funct3 == 3'd5) begin
               if (i_funct7 == F7_BASE) begin
                  o_aluop = ALUOP_SRL;
                  o_shift = 1'b1;
               end else if (i_funct7 == F7_ALT) begin
                  o_aluop = ALUOP_SRA;
                  o_shift = 1'b1;
               end else begin
                  o_illegal = 1'b1;
               end
            end else begin
               o_aluop = base_op(i_funct3);
            end
         end
         OPC_LUI: begin
            o_op1_sel = OP1_ZERO;
            o_op2_sel = OP2_IMM;
         end
         OPC_AUIPC: begin
            o_op1_sel = OP1_PC;
            o_op2_sel = OP2_IMM;
         end
         OPC_JAL: begin
            o_op1_sel = OP1_PC;
            o_op2_sel = OP2_FOUR;
         end
         OPC_JALR: begin
            if (i_funct3 == 3'd0) begin
               o_op1_sel = OP1_PC;
               o_op2_sel = OP2_FOUR;
            end else begin
               o_illegal = 1'b1;
            end
         end
         default: o_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_issue.sv
// Execute-stage issue block: accepts decoded ops, drives registered aluop/operands, holds
// divides for DIV_CYCLES and returns tagged writebacks. RV32M_EN enables mul/div decode.
module alu_issue
   import alu_issue_pkg::*;
#(
   parameter int DIV_CYCLES  = 4,
   parameter int ALU_LATENCY = 1
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [6:0]  in_opcode,
   input  logic [2:0]  in_funct3,
   input  logic [6:0]  in_funct7,
   input  logic [31:0] in_rs1_data,
   input  logic [31:0] in_rs2_data,
   input  logic [31:0] in_imm,
   input  logic [31:0] in_pc,
   input  logic [4:0]  in_rd,
   output logic [4:0]  aluop,
   output logic [31:0] aluin1,
   output logic [31:0] aluin2,
   input  logic [31:0] alu_result,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        wb_illegal
);

   localparam int            CW       = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
   localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [4:0]  w_aluop;
   op1_sel_e    w_op1_sel;
   op2_sel_e    w_op2_sel;
   logic        w_shift, w_is_div, w_illegal, w_accept;
   logic [31:0] w_op1, w_op2_raw, w_op2;
   state_e      r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic        r_ready;
   wb_tag_t     r_pend, w_launch;
   wb_tag_t     r_pipe [0:ALU_LATENCY];
   logic [4:0]  r_aluop;
   logic [31:0] r_aluin1, r_aluin2, r_wb_data;
   logic        r_wb_valid, r_wb_illegal;
   logic [4:0]  r_wb_rd;

   alu_issue_decode u_decode (
      .i_opcode  (in_opcode),
      .i_funct3  (in_funct3),
      .i_funct7  (in_funct7),
      .o_aluop   (w_aluop),
      .o_op1_sel (w_op1_sel),
      .o_op2_sel (w_op2_sel),
      .o_shift   (w_shift),
      .o_is_div  (w_is_div),
      .o_illegal (w_illegal)
   );

   assign w_accept = in_valid & r_ready;

   // operand source selection
   always_comb begin
      w_op1     = in_rs1_data;
      w_op2_raw = in_rs2_data;
      case (w_op1_sel)
         OP1_PC:   w_op1 = in_pc;
         OP1_ZERO: w_op1 = 32'd0;
         default:  w_op1 = in_rs1_data;
      endcase
      case (w_op2_sel)
         OP2_IMM:  w_op2_raw = in_imm;
         OP2_FOUR: w_op2_raw = 32'd4;
         default:  w_op2_raw = in_rs2_data;
      endcase
      if (w_shift) begin
         w_op2 = shamt_zext(w_op2_raw);
      end else begin
         w_op2 = w_op2_raw;
      end
   end

   // issue FSM next state; a divide's tag enters the pipe only when its hold window ends
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_launch    = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (w_is_div && (DIV_CYCLES > 1)) begin
                  w_state_nxt = ST_DIV_HOLD;
                  w_cnt_nxt   = DIV_LOAD;
               end else begin
                  w_launch = '{valid: 1'b1, illegal: w_illegal, rd: in_rd};
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_DIV_HOLD: begin
            if (r_cnt == CNT_ONE) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
               w_launch    = r_pend;
            end else begin
               w_cnt_nxt = r_cnt - CNT_ONE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // state, operand registers, tag pipe and writeback registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_ready      <= 1'b0;
         r_pend       <= '0;
         r_pipe       <= '{default: '0};
         r_aluop      <= 5'd0;
         r_aluin1     <= 32'd0;
         r_aluin2     <= 32'd0;
         r_wb_valid   <= 1'b0;
         r_wb_rd      <= 5'd0;
         r_wb_illegal <= 1'b0;
         r_wb_data    <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ready <= (w_state_nxt == ST_IDLE);
         if (w_accept && !w_illegal) begin
            r_aluop  <= w_aluop;
            r_aluin1 <= w_op1;
            r_aluin2 <= w_op2;
         end
         if (w_accept && w_is_div) begin
            r_pend <= '{valid: 1'b1, illegal: 1'b0, rd: in_rd};
         end
         r_pipe[0] <= w_launch;
         for (int i = 1; i <= ALU_LATENCY; i++) begin
            r_pipe[i] <= r_pipe[i-1];
         end
         r_wb_valid   <= r_pipe[ALU_LATENCY].valid;
         r_wb_rd      <= r_pipe[ALU_LATENCY].rd;
         r_wb_illegal <= r_pipe[ALU_LATENCY].illegal;
         r_wb_data    <= r_pipe[ALU_LATENCY].illegal ? 32'd0 : alu_result;
      end
   end

   assign in_ready   = r_ready;
   assign aluop      = r_aluop;
   assign aluin1     = r_aluin1;
   assign aluin2     = r_aluin2;
   assign wb_valid   = r_wb_valid;
   assign wb_rd      = r_wb_rd;
   assign wb_illegal = r_wb_illegal;
   assign wb_data    = r_wb_data;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed cases plus random traffic against an
// instruction-level reference model and scoreboard; a behavioural ALU closes the loop.
module tb_alu_issue;

   localparam int DC = 4;
`ifdef RV32M_EN
   localparam bit M_EN = 1'b1;
`else
   localparam bit M_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready;
   logic [6:0]  in_opcode, in_funct7;
   logic [2:0]  in_funct3;
   logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
   logic [4:0]  in_rd, aluop, wb_rd;
   logic [31:0] aluin1, aluin2, alu_result, wb_data;
   logic        wb_valid, wb_illegal;

   typedef struct {
      logic [4:0]  rd;
      logic        ill;
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t        sb [$];
   int          checks = 0, fails = 0, cyc = 0, hold_left = 0;
   bit          started = 1'b0, m_ready = 1'b0;
   logic [4:0]  m_op = 5'd0;
   logic [31:0] m_a = 32'd0, m_b = 32'd0;

   always #5 clk = ~clk;

   alu_issue #(.DIV_CYCLES(DC), .ALU_LATENCY(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
      .in_pc(in_pc), .in_rd(in_rd), .aluop(aluop), .aluin1(aluin1), .aluin2(aluin2),
      .alu_result(alu_result), .wb_valid(wb_valid), .wb_rd(wb_rd),
      .wb_data(wb_data), .wb_illegal(wb_illegal)
   );

   // arithmetic meaning of each aluop code
   function automatic logic [31:0] calc(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] sx, sy, ux, uy, p;
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      ux = {32'd0, x};
      uy = {32'd0, y};
      p  = 64'd0;
      case (op)
         5'd0:  return x + y;
         5'd1:  return x - y;
         5'd2:  return x << y[4:0];
         5'd3:  return x ^ y;
         5'd4:  return x >> y[4:0];
         5'd5:  return $unsigned($signed(x) >>> y[4:0]);
         5'd6:  return x | y;
         5'd7:  return x & y;
         5'd8:  return {31'd0, $signed(x) < $signed(y)};
         5'd9:  return {31'd0, x < y};
         5'd16: begin p = sx * sy; return p[63:32]; end
         5'd17: begin p = sx * uy; return p[63:32]; end
         5'd18: begin p = ux * uy; return p[63:32]; end
         5'd22: begin p = ux * uy; return p[31:0]; end
         5'd24: begin
            if (y == 32'd0) return 32'hFFFF_FFFF;
            else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
            else return $unsigned($signed(x) / $signed(y));
         end
         5'd26: return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
         5'd28: begin
            if (y == 32'd0) return x;
            else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
            else return $unsigned($signed(x) % $signed(y));
         end
         5'd30: return (y == 32'd0) ? x : x % y;
         default: return 32'd0;
      endcase
   endfunction

   // external ALU: one register stage
   always_ff @(posedge clk) alu_result <= calc(aluop, aluin1, aluin2);

   // instruction-level reference: aluop, operand pair, legality and divide class
   task automatic ref_dec(output logic [4:0] op, output logic [31:0] x, output logic [31:0] y,
                          output bit ill, output bit dv);
      logic [4:0] optab [8];
      logic [4:0] mtab [8];
      optab = '{5'd0, 5'd2, 5'd8, 5'd9, 5'd3, 5'd4, 5'd6, 5'd7};
      mtab  = '{5'd22, 5'd16, 5'd17, 5'd18, 5'd24, 5'd26, 5'd28, 5'd30};
      op = 5'd0; x = in_rs1_data; y = in_rs2_data; ill = 1'b0; dv = 1'b0;
      case (in_opcode)
         7'h33: begin
            if (in_funct7 == 7'h00) op = optab[in_funct3];
            else if (in_funct7 == 7'h20 && in_funct3 == 3'd0) op = 5'd1;
            else if (in_funct7 == 7'h20 && in_funct3 == 3'd5) op = 5'd5;
            else if (in_funct7 == 7'h01 && M_EN) begin op = mtab[in_funct3]; dv = in_funct3[2]; end
            else ill = 1'b1;
         end
         7'h13: begin
            y = in_imm;
            if (in_funct3 == 3'd1) begin
               if (in_funct7 == 7'h00) op = 5'd2; else ill = 1'b1;
            end else if (in_funct3 == 3'd5) begin
               if (in_funct7 == 7'h00) op = 5'd4;
               else if (in_funct7 == 7'h20) op = 5'd5;
               else ill = 1'b1;
            end else op = optab[in_funct3];
         end
         7'h37: begin x = 32'd0; y = in_imm; end
         7'h17: begin x = in_pc; y = in_imm; end
         7'h6F: begin x = in_pc; y = 32'd4; end
         7'h67: begin
            if (in_funct3 == 3'd0) begin x = in_pc; y = 32'd4; end
            else ill = 1'b1;
         end
         default: ill = 1'b1;
      endcase
      if (op == 5'd2 || op == 5'd4 || op == 5'd5) y = {27'd0, y[4:0]};
   endtask

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
      end
   endtask

   // one clock: check ready, update model on the edge, check outputs on the falling edge
   task automatic step();
      bit acc, ill, dv, exp_v;
      logic [4:0] op;
      logic [31:0] x, y;
      if (started) check_val("in_ready", 32'(in_ready), 32'(m_ready));
      acc = in_valid && m_ready && !rst;
      ill = 1'b0; dv = 1'b0; op = 5'd0; x = 32'd0; y = 32'd0;
      if (acc) ref_dec(op, x, y, ill, dv);
      @(posedge clk);
      cyc++;
      started = 1'b1;
      if (rst) begin
         sb.delete();
         hold_left = 0; m_ready = 1'b0;
         m_op = 5'd0; m_a = 32'd0; m_b = 32'd0;
      end else begin
         if (hold_left > 0) hold_left--;
         if (acc) begin
            if (!ill) begin m_op = op; m_a = x; m_b = y; end
            sb.push_back('{rd: in_rd, ill: ill, data: ill ? 32'd0 : calc(op, x, y),
                           due: cyc + 2 + (dv ? DC - 1 : 0)});
            if (dv) hold_left = DC - 1;
         end
         m_ready = (hold_left == 0);
      end
      @(negedge clk);
      check_val("aluop", 32'(aluop), 32'(m_op));
      check_val("aluin1", aluin1, m_a);
      check_val("aluin2", aluin2, m_b);
      exp_v = (sb.size() > 0) && (sb[0].due <= cyc);
      check_val("wb_valid", 32'(wb_valid), 32'(exp_v));
      if (exp_v) begin
         check_val("wb_rd", 32'(wb_rd), 32'(sb[0].rd));
         check_val("wb_illegal", 32'(wb_illegal), 32'(sb[0].ill));
         check_val("wb_data", wb_data, sb[0].data);
         void'(sb.pop_front());
      end
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) step();
   endtask

   task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                        input logic [31:0] pc, input logic [4:0] rd);
      bit done;
      in_valid = 1'b1; in_opcode = opc; in_funct3 = f3; in_funct7 = f7;
      in_rs1_data = a; in_rs2_data = b; in_imm = imm; in_pc = pc; in_rd = rd;
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         done = m_ready;
         step();
      end
      if (!done) check_val("issue_timeout", 32'd0, 32'd1);
   endtask

   function automatic logic [31:0] rand_val();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'($urandom_range(0, 40));
         default: return $urandom;
      endcase
   endfunction

   task automatic rand_instr();
      logic [6:0] opc, f7;
      case ($urandom_range(0, 8))
         0, 1:    opc = 7'h33;
         2, 3:    opc = 7'h13;
         4:       opc = 7'h37;
         5:       opc = 7'h17;
         6:       opc = 7'h6F;
         7:       opc = 7'h67;
         default: opc = 7'h03;
      endcase
      case ($urandom_range(0, 3))
         0:       f7 = 7'h00;
         1:       f7 = 7'h20;
         2:       f7 = 7'h01;
         default: f7 = 7'($urandom);
      endcase
      in_opcode = opc; in_funct7 = f7; in_funct3 = 3'($urandom);
      in_rs1_data = rand_val(); in_rs2_data = rand_val(); in_imm = rand_val();
      in_pc = $urandom & 32'hFFFF_FFFC; in_rd = 5'($urandom);
      in_valid = ($urandom_range(0, 9) < 7);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_opcode = 7'd0; in_funct3 = 3'd0; in_funct7 = 7'd0;
      in_rs1_data = 32'd0; in_rs2_data = 32'd0; in_imm = 32'd0; in_pc = 32'd0; in_rd = 5'd0;
      idle(2);
      rst = 1'b0;
      idle(1);
      issue(7'h33, 3'd0, 7'h00, 32'd5, 32'd7, 32'd0, 32'd0, 5'd3);
      issue(7'h13, 3'd1, 7'h00, 32'd1, 32'd0, 32'h0000_0421, 32'd0, 5'd4);
      issue(7'h33, 3'd5, 7'h20, 32'h8000_0000, 32'hFFFF_FFE4, 32'd0, 32'd0, 5'd5);
      issue(7'h37, 3'd0, 7'h00, 32'd9, 32'd9, 32'h1234_5000, 32'd0, 5'd6);
      issue(7'h6F, 3'd0, 7'h00, 32'd0, 32'd0, 32'd0, 32'h0000_0100, 5'd1);
      issue(7'h33, 3'd4, 7'h01, -32'sd20, 32'd3, 32'd0, 32'd0, 5'd7);
      issue(7'h33, 3'd0, 7'h00, 32'd10, 32'd20, 32'd0, 32'd0, 5'd8);
      idle(6);
      issue(7'h33, 3'd0, 7'h01, 32'd6, 32'd7, 32'd0, 32'd0, 5'd9);
      idle(4);
      issue(7'h33, 3'd4, 7'h01, -32'sd20, 32'd3, 32'd0, 32'd0, 5'd10);
      idle(1);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      idle(6);
      for (int n = 0; n < 1500; n++) begin
         rand_instr();
         step();
      end
      idle(10);
      check_val("drain", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
